// File: rtl/zork_pkg.sv
// Shared keypad types for the zork top level: debounce states, key code width, named game keys.
// Key codes are {row[1:0], col[1:0]} on a 1-2-3-A / 4-5-6-B / 7-8-9-C / *-0-#-D layout.
package zork_pkg;

    localparam int KEY_W = 4;

    typedef logic [KEY_W-1:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE,
        CANDIDATE,
        PRESSED,
        RELEASE
    } deb_state_t;

    localparam key_code_t KEY_UP     = 4'h1;  // "2"
    localparam key_code_t KEY_LEFT   = 4'h4;  // "4"
    localparam key_code_t KEY_ACTION = 4'h5;  // "5"
    localparam key_code_t KEY_RIGHT  = 4'h6;  // "6"
    localparam key_code_t KEY_DOWN   = 4'h9;  // "8"
    localparam key_code_t KEY_BACK   = 4'hC;  // "*"
    localparam key_code_t KEY_ENTER  = 4'hE;  // "#"

    function automatic key_code_t make_code(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

    // Lowest set column wins; only meaningful when at least one bit is set.
    function automatic logic [1:0] first_col(input logic [3:0] cols);
        if (cols[0]) return 2'd0;
        if (cols[1]) return 2'd1;
        if (cols[2]) return 2'd2;
        return 2'd3;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; 2-cycle latency, no backpressure.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= '0;
            stable <= '0;
        end else begin
            meta   <= d;
            stable <= meta;
        end
    end

    assign q = stable;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-hot row drive, synchronized column sampling, per-scan debounce.
// Press pulse lands on the scan-end cycle of the DEBOUNCE_SCANS-th agreeing scan; no backpressure.
module keypad_scanner
    import zork_pkg::*;
#(
    parameter int ROW_CYCLES     = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk_50MHz_i,
    input  logic             rst_async_la_i,
    input  logic [3:0]       columns_i,
    output logic [3:0]       rows_o,
    output logic [KEY_W-1:0] key_code_o,
    output logic             key_valid_o,
    output logic             key_held_o
);

    localparam int DWELL_W = $clog2(ROW_CYCLES);
    localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROW_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_DONE   = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    logic [3:0]         cols_sync;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         row_idx;
    logic [1:0]         row_nxt;
    logic [3:0]         rows_q;

    logic               sample;
    logic               scan_end;
    logic               row_hit;
    key_code_t          row_code;

    logic               acc_found;
    key_code_t          acc_code;
    logic               scan_found;
    key_code_t          scan_code;

    deb_state_t         state;
    deb_state_t         state_nxt;
    key_code_t          cand;
    key_code_t          cand_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   cnt_inc;
    key_code_t          code_q;
    key_code_t          code_nxt;
    logic               held_q;
    logic               held_nxt;
    logic               valid_c;

    sync_2ff #(
        .WIDTH (4)
    ) u_col_sync (
        .clk   (clk_50MHz_i),
        .rst_n (rst_async_la_i),
        .d     (columns_i),
        .q     (cols_sync)
    );

    assign sample   = (dwell == DWELL_LAST);
    assign scan_end = sample && (row_idx == 2'd3);
    assign row_nxt  = row_idx + 2'd1;
    assign row_hit  = |cols_sync;
    assign row_code = make_code(row_idx, first_col(cols_sync));

    // Row 3's sample is folded in combinationally so the debounce sees the whole scan on scan_end.
    assign scan_found = acc_found | row_hit;
    assign scan_code  = acc_found ? acc_code : row_code;

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            dwell   <= '0;
            row_idx <= 2'd0;
            rows_q  <= 4'b0001;
        end else if (sample) begin
            dwell   <= '0;
            row_idx <= row_nxt;
            rows_q  <= 4'b0001 << row_nxt;
        end else begin
            dwell   <= dwell + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            acc_found <= 1'b0;
            acc_code  <= '0;
        end else if (scan_end) begin
            acc_found <= 1'b0;
            acc_code  <= '0;
        end else if (sample && row_hit && !acc_found) begin
            acc_found <= 1'b1;
            acc_code  <= row_code;
        end
    end

    assign cnt_inc = (cnt == CNT_DONE) ? cnt : cnt + CNT_ONE;

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        code_nxt  = code_q;
        held_nxt  = held_q;
        valid_c   = 1'b0;
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (scan_found) begin
                        state_nxt = CANDIDATE;
                        cand_nxt  = scan_code;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                CANDIDATE: begin
                    if (!scan_found) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (scan_code == cand) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_nxt = PRESSED;
                            code_nxt  = cand;
                            held_nxt  = 1'b1;
                            valid_c   = 1'b1;
                        end
                    end else begin
                        cand_nxt = scan_code;
                        cnt_nxt  = CNT_ONE;
                    end
                end
                PRESSED: begin
                    // A different key without an intervening release is deliberately ignored.
                    if (!scan_found) begin
                        state_nxt = RELEASE;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (scan_found) begin
                        state_nxt = PRESSED;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_nxt = IDLE;
                            held_nxt  = 1'b0;
                            cnt_nxt   = '0;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            state  <= IDLE;
            cand   <= '0;
            cnt    <= '0;
            code_q <= '0;
            held_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cand   <= cand_nxt;
            cnt    <= cnt_nxt;
            code_q <= code_nxt;
            held_q <= held_nxt;
        end
    end

    assign rows_o      = rows_q;
    assign key_code_o  = code_q;
    assign key_valid_o = valid_c;
    assign key_held_o  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scenarios plus random keypad matrices vs a scan-level model.
module tb_keypad_scanner;

    localparam int RC   = 4;
    localparam int DEB  = 3;
    localparam int SCAN = 4 * RC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  columns;
    logic [3:0]  rows;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    // Keypad matrix: bit r*4+c closed means row r / column c pressed.
    logic [15:0] mat = 16'h0000;
    int          t = 0;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;

    bit          m_pressed = 0;
    int          m_run = 0;
    int          m_empty = 0;
    bit          m_last_found = 0;
    logic [3:0]  m_last_code = 4'h0;
    logic [3:0]  m_code = 4'h0;
    bit          m_held = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .ROW_CYCLES     (RC),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk_50MHz_i    (clk),
        .rst_async_la_i (rst_n),
        .columns_i      (columns),
        .rows_o         (rows),
        .key_code_o     (key_code),
        .key_valid_o    (key_valid),
        .key_held_o     (key_held)
    );

    always_comb begin
        columns = 4'b0000;
        for (int r = 0; r < 4; r++)
            if (rows == (4'b0001 << r)) columns = mat[r*4 +: 4];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) t <= 0;
        else        t <= t + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time=%0t)", name, act, exp, t, $time);
        end
    endtask

    function automatic void scan_eval(input logic [15:0] m, output bit found, output logic [3:0] code);
        found = 0;
        code  = 4'h0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!found && m[r*4 + c]) begin
                    found = 1;
                    code  = 4'(r * 4 + c);
                end
    endfunction

    always @(negedge clk) begin
        bit         f;
        logic [3:0] c;
        bit         exp_v;
        if (!rst_n) begin
            check("rst_rows", rows, 4'b0001);
            check("rst_code", key_code, 4'h0);
            check("rst_valid", key_valid, 1'b0);
            check("rst_held", key_held, 1'b0);
            m_pressed = 0; m_run = 0; m_empty = 0; m_last_found = 0;
            m_last_code = 4'h0; m_code = 4'h0; m_held = 0;
        end else begin
            check("rows", rows, 32'(1) << ((t / RC) % 4));
            check("code", key_code, m_code);
            check("held", key_held, m_held);
            exp_v = 0;
            if (t % SCAN == SCAN - 1) begin
                scan_eval(mat, f, c);
                if (!m_pressed) begin
                    if (f && m_last_found && c == m_last_code) m_run++;
                    else m_run = f ? 1 : 0;
                    if (m_run == DEB) begin
                        m_pressed = 1; exp_v = 1; m_code = c; m_held = 1; m_empty = 0;
                    end
                end else begin
                    if (f) m_empty = 0;
                    else   m_empty++;
                    if (m_empty == DEB) begin
                        m_pressed = 0; m_held = 0; m_run = 0;
                    end
                end
                m_last_found = f;
                m_last_code  = c;
            end
            check("valid", key_valid, exp_v);
            if (key_valid === 1'b1) pulses++;
        end
    end

    // Waits for the next scan start (first negedge of a scan) and installs the matrix for that scan.
    task automatic next_scan(input logic [15:0] m);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((t % SCAN != 0 || !rst_n) && n < 4 * SCAN);
        if (n >= 4 * SCAN) begin
            checks++;
            errors++;
            $display("FAIL scan_wait: got no scan start within %0d cycles expected one", n);
        end
        mat = m;
    endtask

    task automatic wait_t(input int target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (t != target && n < 4 * SCAN);
        check("wait_t", t, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         p0;
        logic [15:0] prev;
        logic [15:0] m;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        wait_t(4);
        check("rows_t4", rows, 4'b0010);
        wait_t(12);
        check("rows_t12", rows, 4'b1000);

        // Single press: row2/col1
        p0 = pulses;
        repeat (3) next_scan(16'h0200);
        next_scan(16'h0200);
        check("press_pulses", pulses - p0, 1);
        check("press_code", key_code, 4'h9);
        check("press_held", key_held, 1'b1);
        repeat (10) next_scan(16'h0200);
        check("hold_pulses", pulses - p0, 1);

        // Release
        p0 = pulses;
        repeat (3) next_scan(16'h0000);
        check("rel_held_2", key_held, 1'b1);
        next_scan(16'h0000);
        check("rel_held_3", key_held, 1'b0);
        check("rel_code", key_code, 4'h9);
        check("rel_pulses", pulses - p0, 0);

        // Bounce
        p0 = pulses;
        for (int i = 0; i < 12; i++) next_scan((i % 2 == 0) ? 16'h0001 : 16'h0000);
        next_scan(16'h0000);
        check("bounce_pulses", pulses - p0, 0);
        check("bounce_held", key_held, 1'b0);

        // Priority: row1/col3 and row3/col0
        p0 = pulses;
        repeat (4) next_scan(16'h1080);
        check("prio_pulses", pulses - p0, 1);
        check("prio_code", key_code, 4'h7);
        check("prio_held", key_held, 1'b1);

        // Asynchronous reset mid-press, between clock edges
        #3 rst_n = 1'b0;
        #1;
        check("arst_rows", rows, 4'b0001);
        check("arst_code", key_code, 4'h0);
        check("arst_held", key_held, 1'b0);
        check("arst_valid", key_valid, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        p0 = pulses;
        repeat (3) next_scan(16'h1080);
        next_scan(16'h1080);
        check("arst_pulses", pulses - p0, 1);
        check("arst_code2", key_code, 4'h7);
        check("arst_held2", key_held, 1'b1);
        repeat (4) next_scan(16'h0000);

        // Random keypad activity, biased toward keys held for several scans
        prev = 16'h0000;
        repeat (90) begin
            case ($urandom_range(0, 9))
                0, 1, 2:    m = 16'h0000;
                3, 4, 5, 6: m = prev;
                7, 8:       m = 16'h0001 << $urandom_range(0, 15);
                default:    m = 16'($urandom);
            endcase
            next_scan(m);
            prev = m;
        end
        next_scan(16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
